// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: word address layout and arbiter states.
// Used by the arbiter and by clients that build SDRAM addresses.
package sdram_pkg;

  localparam int AddrWidth = 23;
  localparam int DataWidth = 16;

  // Word address = {bank, row, col}
  localparam int BankHi = 22;
  localparam int BankLo = 21;
  localparam int RowHi  = 20;
  localparam int RowLo  = 9;
  localparam int ColHi  = 8;
  localparam int ColLo  = 0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  function automatic logic [1:0] addr_bank(
    input logic [AddrWidth-1:0] a
  );
    return a[BankHi:BankLo];
  endfunction

  function automatic logic [11:0] addr_row(
    input logic [AddrWidth-1:0] a
  );
    return a[RowHi:RowLo];
  endfunction

  function automatic logic [8:0] addr_col(
    input logic [AddrWidth-1:0] a
  );
    return a[ColHi:ColLo];
  endfunction

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// Rotate-priority picker: first set req bit after last_grant, wrapping.
// Ports: req vector, last_grant index in; valid and grant index out.
module rr_pick #(
  parameter int PortCount  = 3,
  parameter int GrantWidth = $clog2(PortCount)
) (
  input  logic [PortCount-1:0]  req,
  input  logic [GrantWidth-1:0] last_grant,
  output logic                  valid,
  output logic [GrantWidth-1:0] grant
);

  int                  idx;
  logic [GrantWidth-1:0] idx_g;

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    idx   = 0;
    idx_g = '0;
    for (int i = PortCount; i >= 1; i--) begin
      idx = int'(last_grant) + i;
      if (idx >= PortCount) idx = idx - PortCount;
      idx_g = GrantWidth'(idx);
      if (req[idx_g]) begin
        valid = 1'b1;
        grant = idx_g;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port.
// Ports: clk, rst_ (async low), per-port req_*, shared ctrl_* port.
module sdram_arbiter #(
  parameter int PortCount = 3,
  parameter int AddrWidth = sdram_pkg::AddrWidth,
  parameter int DataWidth = sdram_pkg::DataWidth
) (
  input  logic                           clk,
  input  logic                           rst_,
  input  logic [PortCount-1:0]           req_trigger,
  input  logic [PortCount*AddrWidth-1:0] req_addr,
  input  logic [PortCount-1:0]           req_write,
  input  logic [PortCount*DataWidth-1:0] req_write_data,
  output logic [PortCount-1:0]           req_accept,
  output logic [PortCount-1:0]           req_done,
  output logic [DataWidth-1:0]           req_read_data,
  output logic                           ctrl_trigger,
  output logic [AddrWidth-1:0]           ctrl_addr,
  output logic                           ctrl_write,
  output logic [DataWidth-1:0]           ctrl_write_data,
  input  logic [DataWidth-1:0]           ctrl_read_data,
  input  logic                           ctrl_done
);

  import sdram_pkg::*;

  localparam int GW = $clog2(PortCount);
  localparam logic [GW-1:0] LastInit = GW'(PortCount - 1);
  localparam logic [PortCount-1:0] OneHot = PortCount'(1);

  arb_state_t state, state_n;

  logic [GW-1:0] grant;
  logic [GW-1:0] last_grant;
  logic          pick_valid;
  logic [GW-1:0] pick_grant;

  logic [1:0] busy_cnt, busy_cnt_n;
  logic       err_no_ack;

  logic do_accept;
  logic do_issue;
  logic do_done;
  logic set_err;

  logic [AddrWidth-1:0] sel_addr;
  logic                 sel_write;
  logic [DataWidth-1:0] sel_wdata;

  rr_pick #(
    .PortCount (PortCount),
    .GrantWidth(GW)
  ) u_pick (
    .req       (req_trigger),
    .last_grant(last_grant),
    .valid     (pick_valid),
    .grant     (pick_grant)
  );

  always_comb begin
    sel_addr  = '0;
    sel_write = 1'b0;
    sel_wdata = '0;
    for (int p = 0; p < PortCount; p++) begin
      if (pick_grant == GW'(p)) begin
        sel_addr  = req_addr[p*AddrWidth +: AddrWidth];
        sel_write = req_write[p];
        sel_wdata = req_write_data[p*DataWidth +: DataWidth];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      busy_cnt <= '0;
    end else begin
      state    <= state_n;
      busy_cnt <= busy_cnt_n;
    end
  end

  // busy_cnt counts WAIT_BUSY cycles; a controller that has not
  // dropped ctrl_done by the third one is treated as having
  // accepted anyway so the requester is not stranded.
  always_comb begin
    state_n    = state;
    busy_cnt_n = '0;
    do_accept  = 1'b0;
    do_issue   = 1'b0;
    do_done    = 1'b0;
    set_err    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid && ctrl_done) begin
          do_accept = 1'b1;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        do_issue = 1'b1;
        state_n  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!ctrl_done) begin
          state_n = WAIT_DONE;
        end else if (busy_cnt == 2'd2) begin
          set_err = 1'b1;
          state_n = WAIT_DONE;
        end else begin
          busy_cnt_n = busy_cnt + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (ctrl_done) begin
          do_done = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      grant           <= '0;
      last_grant      <= LastInit;
      req_accept      <= '0;
      req_done        <= '0;
      req_read_data   <= '0;
      ctrl_trigger    <= 1'b0;
      ctrl_addr       <= '0;
      ctrl_write      <= 1'b0;
      ctrl_write_data <= '0;
      err_no_ack      <= 1'b0;
    end else begin
      req_accept   <= '0;
      req_done     <= '0;
      ctrl_trigger <= do_issue;
      err_no_ack   <= err_no_ack | set_err;
      if (do_accept) begin
        grant           <= pick_grant;
        last_grant      <= pick_grant;
        req_accept      <= OneHot << pick_grant;
        ctrl_addr       <= sel_addr;
        ctrl_write      <= sel_write;
        ctrl_write_data <= sel_wdata;
      end
      if (do_done) begin
        req_done <= OneHot << grant;
        if (!ctrl_write) req_read_data <= ctrl_read_data;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: controller model, scoreboard monitor,
// directed scenarios then randomized multi-port traffic.
module tb_sdram_arbiter;

  localparam int N  = 3;
  localparam int AW = sdram_pkg::AddrWidth;
  localparam int DW = sdram_pkg::DataWidth;

  logic clk  = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_trigger    = '0;
  logic [N*AW-1:0] req_addr       = '0;
  logic [N-1:0]    req_write      = '0;
  logic [N*DW-1:0] req_write_data = '0;
  logic [N-1:0]    req_accept;
  logic [N-1:0]    req_done;
  logic [DW-1:0]   req_read_data;
  logic            ctrl_trigger;
  logic [AW-1:0]   ctrl_addr;
  logic            ctrl_write;
  logic [DW-1:0]   ctrl_write_data;
  logic [DW-1:0]   ctrl_read_data = '0;
  logic            ctrl_done      = 1'b1;

  sdram_arbiter #(
    .PortCount(N),
    .AddrWidth(AW),
    .DataWidth(DW)
  ) dut (
    .clk            (clk),
    .rst_           (rst_),
    .req_trigger    (req_trigger),
    .req_addr       (req_addr),
    .req_write      (req_write),
    .req_write_data (req_write_data),
    .req_accept     (req_accept),
    .req_done       (req_done),
    .req_read_data  (req_read_data),
    .ctrl_trigger   (ctrl_trigger),
    .ctrl_addr      (ctrl_addr),
    .ctrl_write     (ctrl_write),
    .ctrl_write_data(ctrl_write_data),
    .ctrl_read_data (ctrl_read_data),
    .ctrl_done      (ctrl_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- SDRAM controller model ----------------
  logic [DW-1:0] sdram [logic [AW-1:0]];
  int            c_phase   = 0;
  int            c_cnt     = 0;
  int            c_lat     = 3;
  int            c_ackdly  = 1;
  bit            c_randlat = 0;
  bit            c_hold_ok = 1;
  logic [AW-1:0] c_addr;
  logic          c_wr;
  logic [DW-1:0] c_wd;

  task automatic hold_chk();
    if (ctrl_addr !== c_addr || ctrl_write !== c_wr ||
        ctrl_write_data !== c_wd)
      c_hold_ok = 0;
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_) begin
      c_phase   = 0;
      ctrl_done = 1'b1;
    end else begin
      case (c_phase)
        0: if (ctrl_trigger) begin
          c_addr    = ctrl_addr;
          c_wr      = ctrl_write;
          c_wd      = ctrl_write_data;
          c_hold_ok = 1;
          c_cnt     = c_ackdly;
          c_phase   = 1;
        end
        1: begin
          hold_chk();
          c_cnt--;
          if (c_cnt == 0) begin
            ctrl_done = 1'b0;
            c_cnt = c_randlat ? int'($urandom_range(1, 6)) : c_lat;
            c_phase = 2;
          end
        end
        default: begin
          hold_chk();
          c_cnt--;
          if (c_cnt == 0) begin
            if (c_wr) sdram[c_addr] = c_wd;
            else ctrl_read_data = sdram.exists(c_addr) ?
                                  sdram[c_addr] : dflt(c_addr);
            ctrl_done = 1'b1;
            c_phase   = 0;
            chk("ctrl_hold", 64'(c_hold_ok), 64'(1));
          end
        end
      endcase
    end
  end

  // ---------------- reference model + monitor ----------------
  typedef struct {
    int            port;
    bit            wr;
    logic [DW-1:0] rd;
  } done_t;

  logic [DW-1:0] mem_ref [logic [AW-1:0]];
  done_t         dq[$];
  int            glog[$];
  int            acc_cyc[$];
  int            done_cyc[$];
  bit            busy_m = 0;
  bit            due    = 0;
  int            last_m = N - 1;
  int            acc_n  = 0;
  int            trg_n  = 0;
  logic [DW-1:0] rd_m   = '0;
  logic [N-1:0]    trig_p = '0;
  logic [N*AW-1:0] addr_p = '0;
  logic [N-1:0]    wr_p   = '0;
  logic [N*DW-1:0] wd_p   = '0;
  logic [AW-1:0] pend_addr;
  logic          pend_wr;
  logic [DW-1:0] pend_wd;
  int            pend_port;

  // Next winner: first requester after the previous winner, wrapping.
  function automatic int rr_exp(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int first_bit(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst_) begin
      busy_m = 0;
      due    = 0;
      last_m = N - 1;
      rd_m   = '0;
      trig_p = '0;
      dq.delete();
    end else begin
      if (due) begin
        done_t e;
        chk("trig_after_accept", 64'(ctrl_trigger), 64'(1));
        chk("cmd_addr", 64'(ctrl_addr), 64'(pend_addr));
        chk("cmd_write", 64'(ctrl_write), 64'(pend_wr));
        if (pend_wr)
          chk("cmd_wdata", 64'(ctrl_write_data), 64'(pend_wd));
        e.port = pend_port;
        e.wr   = pend_wr;
        e.rd   = mem_ref.exists(pend_addr) ?
                 mem_ref[pend_addr] : dflt(pend_addr);
        if (pend_wr) mem_ref[pend_addr] = pend_wd;
        dq.push_back(e);
        due = 0;
        trg_n++;
      end else if (ctrl_trigger) begin
        chk("unexpected_trig", 64'(ctrl_trigger), 64'(0));
        trg_n++;
      end

      if (|req_accept) begin
        int eg, ag;
        chk("accept_onehot", 64'($onehot(req_accept)), 64'(1));
        eg = busy_m ? -1 : rr_exp(last_m, trig_p);
        ag = first_bit(req_accept);
        chk("grant", 64'(ag), 64'(eg));
        acc_n++;
        glog.push_back(ag);
        acc_cyc.push_back(cyc);
        if (eg >= 0) begin
          last_m    = eg;
          pend_port = eg;
          pend_addr = addr_p[eg*AW +: AW];
          pend_wr   = wr_p[eg];
          pend_wd   = wd_p[eg*DW +: DW];
          due       = 1;
          busy_m    = 1;
        end
      end else if (!busy_m && |trig_p) begin
        chk("missed_accept", 64'(req_accept),
            64'(1) << rr_exp(last_m, trig_p));
      end

      if (|req_done) begin
        chk("done_onehot", 64'($onehot(req_done)), 64'(1));
        if (dq.size() == 0) begin
          chk("unexpected_done", 64'(req_done), 64'(0));
        end else begin
          done_t e;
          e = dq.pop_front();
          chk("done_port", 64'(req_done), 64'(1) << e.port);
          if (e.wr) begin
            chk("rd_held_on_write", 64'(req_read_data), 64'(rd_m));
          end else begin
            chk("read_data", 64'(req_read_data), 64'(e.rd));
            rd_m = e.rd;
          end
        end
        busy_m = 0;
        done_cyc.push_back(cyc);
      end

      trig_p = req_trigger;
      addr_p = req_addr;
      wr_p   = req_write;
      wd_p   = req_write_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int p, input logic [AW-1:0] a,
                         input logic w, input logic [DW-1:0] d);
    req_addr[p*AW +: AW]       = a;
    req_write[p]               = w;
    req_write_data[p*DW +: DW] = d;
    req_trigger[p]             = 1'b1;
  endtask

  task automatic wait_acc(input int p, input string name);
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (req_accept[p]) break;
      n++;
    end
    if (n >= 300) timeout(name);
  endtask

  task automatic wait_done(input int p, input string name);
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (req_done[p]) break;
      n++;
    end
    if (n >= 300) timeout(name);
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (ctrl_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout(name);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while ((busy_m || due || dq.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) timeout(name);
  endtask

  task automatic drop(input int p);
    @(posedge clk);
    #1 req_trigger[p] = 1'b0;
  endtask

  task automatic requester(input int p, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      set_req(p, AW'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), DW'($urandom));
      wait_acc(p, "rand_accept");
      drop(p);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({req_accept, req_done, req_read_data, ctrl_trigger,
                ctrl_addr, ctrl_write, ctrl_write_data});
  endfunction

  // ---------------- scenarios ----------------
  initial begin
    int got, n, n0, t0;

    #2 rst_ = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'(0));
    chk("reset_err", 64'(dut.err_no_ack), 64'(0));
    #2 rst_ = 1'b1;

    // All ports contend continuously for six commands.
    glog.delete();
    acc_cyc.delete();
    done_cyc.delete();
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++)
      set_req(p, AW'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), DW'($urandom));
    got = 0;
    n   = 0;
    while (got < 6 && n < 600) begin
      @(negedge clk);
      if (|req_accept) got++;
      n++;
    end
    if (got < 6) timeout("contend_accepts");
    @(posedge clk);
    #1 req_trigger = '0;
    wait_idle("contend_idle");
    chk("contend_count", 64'(glog.size()), 64'(6));
    for (int k = 0; k < 6 && k < glog.size(); k++)
      chk("contend_order", 64'(glog[k]), 64'(k % N));
    for (int k = 1; k < 6 && k < acc_cyc.size() &&
         k <= done_cyc.size(); k++)
      chk("contend_gap", 64'(acc_cyc[k]), 64'(done_cyc[k-1] + 1));

    // Single read from port 1.
    sdram[23'h1A0005]   = 16'hBEEF;
    mem_ref[23'h1A0005] = 16'hBEEF;
    @(posedge clk);
    #1 set_req(1, 23'h1A0005, 1'b0, '0);
    wait_acc(1, "single_accept");
    drop(1);
    @(negedge clk);
    chk("single_trig", 64'(ctrl_trigger), 64'(1));
    chk("single_addr", 64'(ctrl_addr), 64'(23'h1A0005));
    chk("single_write", 64'(ctrl_write), 64'(0));
    wait_done(1, "single_done");
    chk("single_rdata", 64'(req_read_data), 64'(16'hBEEF));
    wait_idle("single_idle");

    // Long write from port 2; read data must stay untouched.
    c_lat = 10;
    @(posedge clk);
    #1 set_req(2, 23'h000100, 1'b1, 16'h1234);
    wait_acc(2, "write_accept");
    drop(2);
    wait_done(2, "write_done");
    chk("write_rd_held", 64'(req_read_data), 64'(16'hBEEF));
    wait_idle("write_idle");

    // Port 0 raises then withdraws while port 1 is in flight.
    c_lat = 8;
    @(posedge clk);
    #1 set_req(1, 23'h0ABCDE, 1'b0, '0);
    wait_acc(1, "wd_accept");
    drop(1);
    wait_busy("wd_busy");
    n0 = acc_n;
    t0 = trg_n;
    @(posedge clk);
    #1 set_req(0, 23'h012345, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1 req_trigger[0] = 1'b0;
    wait_done(1, "wd_done");
    repeat (6) @(negedge clk);
    chk("withdraw_no_accept", 64'(acc_n), 64'(n0));
    chk("withdraw_no_trig", 64'(trg_n), 64'(t0));
    wait_idle("wd_idle");

    // Controller slow to drop ctrl_done.
    c_lat = 3;
    chk("err_clear", 64'(dut.err_no_ack), 64'(0));
    c_ackdly = 3;
    @(posedge clk);
    #1 set_req(2, 23'h155555, 1'b1, 16'hCAFE);
    wait_acc(2, "noack_accept");
    drop(2);
    wait_done(2, "noack_done");
    chk("err_set", 64'(dut.err_no_ack), 64'(1));
    c_ackdly = 1;
    wait_idle("noack_idle");
    @(posedge clk);
    #1 set_req(0, 23'h155555, 1'b0, '0);
    wait_acc(0, "noack_rb_accept");
    drop(0);
    wait_done(0, "noack_rb_done");
    chk("noack_readback", 64'(req_read_data), 64'(16'hCAFE));
    wait_idle("noack_rb_idle");

    // Asynchronous reset in the middle of a read.
    c_lat = 12;
    @(posedge clk);
    #1 set_req(1, 23'h0F0F0F, 1'b0, '0);
    wait_acc(1, "mid_accept");
    drop(1);
    wait_busy("mid_busy");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_ = 1'b0;
    #1;
    chk("midreset_outputs", all_outs(), 64'(0));
    chk("midreset_err", 64'(dut.err_no_ack), 64'(0));
    got = 0;
    repeat (3) begin
      @(negedge clk);
      if (|req_done) got++;
    end
    chk("midreset_no_done", 64'(got), 64'(0));
    #2 rst_ = 1'b1;
    c_lat = 3;
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++)
      set_req(p, AW'(p + 40), 1'b0, '0);
    n = 0;
    while (req_accept == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("postreset_accept");
    chk("postreset_first", 64'(req_accept), 64'(3'b001));
    @(posedge clk);
    #1 req_trigger = '0;
    wait_idle("postreset_idle");

    // Randomized traffic on all ports.
    c_randlat = 1;
    for (int p = 0; p < N; p++) begin
      fork
        automatic int pp = p;
        requester(pp, 10);
      join_none
    end
    wait fork;
    wait_idle("rand_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller command port (trigger/addr/write/write-data/read-data/done) between PortCount requesters with round-robin fairness.
- Sits between client blocks (pixel capture, readout, test logic) and the SDRAM controller.
- Serialises commands: one command outstanding at the controller at a time.
- Returns completion and read data to the port that issued the command.

Parameters:
- PortCount, 3, number of requester ports (2..8).
- AddrWidth, 23, word address width (bank 2 + row 12 + col 9).
- DataWidth, 16, SDRAM data word width.

Ports:
- clk  in  1  system clock (same domain as SDRAM controller).
- rst_  in  1  reset: asynchronous, active-low.
- req_trigger  in  PortCount  per-port request; level, held until req_accept.
- req_addr  in  PortCount*AddrWidth  per-port address; port i at [i*AddrWidth +: AddrWidth].
- req_write  in  PortCount  per-port 1=write, 0=read.
- req_write_data  in  PortCount*DataWidth  per-port write data.
- req_accept  out  PortCount  one-cycle pulse: port's command issued; requester may change inputs next cycle.
- req_done  out  PortCount  one-cycle pulse: port's command complete.
- req_read_data  out  DataWidth  shared read data; valid in the req_done cycle of a read, held until the next completion.
- ctrl_trigger  out  1  one-cycle command pulse to controller.
- ctrl_addr  out  AddrWidth  command address, held stable from trigger to completion.
- ctrl_write  out  1  command direction, held like ctrl_addr.
- ctrl_write_data  out  DataWidth  write data, held like ctrl_addr.
- ctrl_read_data  in  DataWidth  controller read data, valid when ctrl_done rises after a read.
- ctrl_done  in  1  controller idle/ready; drops within 2 cycles of an accepted trigger, rises when the command completes.

Behaviour:
- Reset (rst_ low, asynchronous):
  - state=IDLE, last_grant=PortCount-1, so port 0 wins first.
  - All outputs 0, including req_read_data, ctrl_addr and ctrl_write_data.
  - Reset mid-command abandons it: no req_done is issued; the controller is reset by the same rst_ domain.
- States: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
- IDLE:
  - Condition: any req_trigger high and ctrl_done=1.
  - Pick the first requesting port scanning last_grant+1, +2, ... modulo PortCount.
  - Register grant and last_grant=grant, and capture that port's addr/write/write_data into the ctrl_* registers.
  - Pulse req_accept[grant]; go to ISSUE.
  - Requests are sampled only in IDLE; a trigger dropped before accept is never served.
- ISSUE: ctrl_trigger=1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for ctrl_done=0, then go to WAIT_DONE.
  - If ctrl_done is still 1 after 2 cycles in WAIT_BUSY, set the sticky internal error flag err_no_ack (debug only) and go to WAIT_DONE anyway.
- WAIT_DONE: on ctrl_done=1:
  - Pulse req_done[grant].
  - If ctrl_write=0, register ctrl_read_data into req_read_data in the same cycle.
  - Go to IDLE.
- Latency:
  - req_trigger high in IDLE -> req_accept next edge -> ctrl_trigger 1 cycle later.
  - Completion -> req_done 1 cycle after ctrl_done rises.
  - Minimum 1 IDLE cycle between commands.
- Fairness: with all ports requesting continuously, grants rotate 0,1,...,PortCount-1,0. No port waits more than PortCount-1 other commands.
- Simultaneous events:
  - New requests arriving during WAIT_* wait for IDLE.
  - A port may re-raise req_trigger in the cycle after its req_done; it is considered in the next IDLE arbitration with lowest priority.
- Exclusivity: req_accept and req_done are one-hot or zero; never more than one bit set.
- Widths: grant and last_grant are $clog2(PortCount) wide; the modulo wrap is explicit (no reliance on power-of-2 PortCount).

Decomposition:
- Shared package sdram_pkg:
  - AddrWidth, DataWidth.
  - Address field slices: bank [22:21], row [20:9], col [8:0].
  - Arbiter state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE).
- Sub-module rr_pick: combinational rotate-priority picker; inputs req vector and last_grant; outputs valid and grant index. Reused by other shared resources.

Test Plan:
- Single read: port 1 requests read at 23'h1A_0005; model returns 16'hBEEF.
  - Response: req_accept[1] one cycle, ctrl_trigger one cycle later with ctrl_addr=23'h1A_0005 and ctrl_write=0.
  - req_done[1] pulses with req_read_data=16'hBEEF.
- All ports contend: PortCount=3, all requesting continuously for 6 commands.
  - Response: grant order 0,1,2,0,1,2; each ctrl_trigger preceded by exactly one IDLE cycle gap.
- Write hold: port 2 writes 16'h1234 to 23'h00_0100; model holds ctrl_done low 10 cycles.
  - Response: ctrl_addr and ctrl_write_data stay stable throughout; req_read_data is unchanged after req_done[2].
- Withdrawn request: port 0 raises req_trigger while port 1's command is in WAIT_DONE, then drops it before completion.
  - Response: no req_accept[0], no ctrl_trigger after port 1's completion.
- Reset mid-command: assert rst_ low asynchronously (mid-cycle) in WAIT_DONE.
  - Response: all outputs 0 immediately, no req_done; after release, port 0 wins the first arbitration.
- Non-acking controller: ctrl_done stays 1 for 3 cycles after the trigger, then drops and completes.
  - Response: err_no_ack set; completion still delivered to the granted port.
